// File: rtl/int_to_float.sv
`default_nettype none
// ============================================================================
// Module   : int_to_float
// Purpose  : Converts a 32-bit two's-complement signed integer into an
//            IEEE-754 binary32 value with round-to-nearest-even rounding.
//            Both sides use a stb/ack streaming handshake. Only one operand
//            is in flight at a time.
// Ports    : clk           - clock, all logic on the rising edge
//            rst           - synchronous, active-low reset
//            input_a       - signed integer operand
//            input_a_stb   - upstream valid
//            input_a_ack   - block ready (registered)
//            output_z      - binary32 result (registered)
//            output_z_stb  - result valid (registered)
//            output_z_ack  - downstream accepts result
// Options  : INT_TO_FLOAT_FAST_NORMALISE_EN - when defined, normalisation is
//            done in a single cycle by a leading-zero priority encoder.
//            When undefined, the mantissa is shifted one bit per cycle.
//            Results are bit-identical in both builds.
// Revision : 1.0 - initial release
// ============================================================================
module int_to_float (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  typedef enum logic [2:0] {
    S_GET_A     = 3'd0,
    S_CONVERT_0 = 3'd1,
    S_CONVERT_1 = 3'd2,
    S_ROUND     = 3'd3,
    S_PACK      = 3'd4,
    S_PUT_Z     = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        mag_q, mag_d;
  logic signed [7:0]  z_e_q, z_e_d;
  logic               z_s_q, z_s_d;
  logic [23:0]        z_m_q, z_m_d;
  logic               guard_q, guard_d;
  logic               round_bit_q, round_bit_d;
  logic               sticky_q, sticky_d;
  logic [31:0]        z_q, z_d;
  logic               ack_q, ack_d;
  logic               stb_q, stb_d;
  logic [31:0]        out_q, out_d;

  // Biased exponent for packing; |a| <= 2^31 keeps it inside the normal range.
  logic [7:0]         biased_exp;
  assign biased_exp = z_e_q + 8'sd127;

`ifdef INT_TO_FLOAT_FAST_NORMALISE_EN
  // Leading-zero count of the magnitude. The highest set bit is written last
  // and therefore wins. The magnitude is never zero in convert_1.
  logic [4:0]  lz;
  logic [31:0] norm;

  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (mag_q[i]) begin
        lz = 5'(31 - i);
      end
    end
  end

  assign norm = mag_q << lz;
`endif

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    mag_d       = mag_q;
    z_e_d       = z_e_q;
    z_s_d       = z_s_q;
    z_m_d       = z_m_q;
    guard_d     = guard_q;
    round_bit_d = round_bit_q;
    sticky_d    = sticky_q;
    z_d         = z_q;
    ack_d       = ack_q;
    stb_d       = stb_q;
    out_d       = out_q;

    case (state_q)
      S_GET_A: begin
        ack_d = 1'b1;
        if (ack_q && input_a_stb) begin
          a_d     = input_a;
          ack_d   = 1'b0;
          state_d = S_CONVERT_0;
        end
      end

      S_CONVERT_0: begin
        if (a_q == 32'd0) begin
          // Zero bypasses normalisation and is always +0.
          z_d     = 32'h0000_0000;
          state_d = S_PUT_Z;
        end else begin
          z_s_d   = a_q[31];
          // Negating 0x80000000 wraps back to 0x80000000, which is exactly
          // the correct unsigned magnitude 2^31.
          mag_d   = a_q[31] ? (~a_q + 32'd1) : a_q;
          z_e_d   = 8'sd31;
          state_d = S_CONVERT_1;
        end
      end

      S_CONVERT_1: begin
`ifdef INT_TO_FLOAT_FAST_NORMALISE_EN
        mag_d       = norm;
        z_e_d       = 8'sd31 - $signed({3'b000, lz});
        z_m_d       = norm[31:8];
        guard_d     = norm[7];
        round_bit_d = norm[6];
        sticky_d    = |norm[5:0];
        state_d     = S_ROUND;
`else
        if (!mag_q[31]) begin
          mag_d = mag_q << 1;
          z_e_d = z_e_q - 8'sd1;
        end else begin
          z_m_d       = mag_q[31:8];
          guard_d     = mag_q[7];
          round_bit_d = mag_q[6];
          sticky_d    = |mag_q[5:0];
          state_d     = S_ROUND;
        end
`endif
      end

      S_ROUND: begin
        if (guard_q && (round_bit_q || sticky_q || z_m_q[0])) begin
          z_m_d = z_m_q + 24'd1;
          // Mantissa overflow: wraps to zero, the hidden bit stays implicit
          // and the exponent absorbs the carry.
          if (z_m_q == 24'hFF_FFFF) begin
            z_e_d = z_e_q + 8'sd1;
          end
        end
        state_d = S_PACK;
      end

      S_PACK: begin
        z_d     = {z_s_q, biased_exp, z_m_q[22:0]};
        state_d = S_PUT_Z;
      end

      S_PUT_Z: begin
        stb_d = 1'b1;
        out_d = z_q;
        if (stb_q && output_z_ack) begin
          stb_d   = 1'b0;
          state_d = S_GET_A;
        end
      end

      default: begin
        state_d = S_GET_A;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_GET_A;
      a_q         <= 32'd0;
      mag_q       <= 32'd0;
      z_e_q       <= 8'sd0;
      z_s_q       <= 1'b0;
      z_m_q       <= 24'd0;
      guard_q     <= 1'b0;
      round_bit_q <= 1'b0;
      sticky_q    <= 1'b0;
      z_q         <= 32'd0;
      ack_q       <= 1'b0;
      stb_q       <= 1'b0;
      out_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      mag_q       <= mag_d;
      z_e_q       <= z_e_d;
      z_s_q       <= z_s_d;
      z_m_q       <= z_m_d;
      guard_q     <= guard_d;
      round_bit_q <= round_bit_d;
      sticky_q    <= sticky_d;
      z_q         <= z_d;
      ack_q       <= ack_d;
      stb_q       <= stb_d;
      out_q       <= out_d;
    end
  end

  assign input_a_ack  = ack_q;
  assign output_z_stb = stb_q;
  assign output_z     = out_q;

endmodule
`default_nettype wire

// File: tb/tb_int_to_float.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_to_float
// Purpose  : Self-checking bench for int_to_float. Expected results and
//            latencies are pushed to queues when an operand is accepted and
//            popped when the result appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_int_to_float;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] input_a = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [31:0] sb_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  int_to_float dut (
    .clk          (clk),
    .rst          (rst),
    .input_a      (input_a),
    .input_a_stb  (input_a_stb),
    .input_a_ack  (input_a_ack),
    .output_z     (output_z),
    .output_z_stb (output_z_stb),
    .output_z_ack (output_z_ack)
  );

  // Reference conversion: locate the MSB, then round the dropped bits by
  // comparing the remainder with one half ulp.
  function automatic logic [31:0] ref_float(input logic [31:0] a);
    logic        s;
    logic [63:0] mag, q, rem, half;
    logic [7:0]  ev;
    int          p, sh;
    if (a == 32'd0) return 32'd0;
    s   = a[31];
    mag = {32'd0, a};
    if (s) mag = 64'h1_0000_0000 - mag;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 64'd1;
      if (q == (64'd1 << 24)) begin
        q = q >> 1;
        p = p + 1;
      end
    end
    ev = 8'(p + 127);
    return {s, ev, q[22:0]};
  endfunction

  function automatic int ref_latency(input logic [31:0] a);
    logic [31:0] mag;
    int          p;
    if (a == 32'd0) return 2;
    mag = a[31] ? (32'd0 - a) : a;
    p = 0;
    for (int i = 0; i < 32; i++) if (mag[i]) p = i;
`ifdef INT_TO_FLOAT_FAST_NORMALISE_EN
    return 5;
`else
    return 5 + (31 - p);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Wait for ready, present the operand for the accepting edge, record the
  // expectation. Returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] a);
    int n = 0;
    while (!input_a_ack && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", {31'd0, input_a_ack}, 32'd1);
    input_a     = a;
    input_a_stb = 1'b1;
    sb_q.push_back(ref_float(a));
    lat_q.push_back(ref_latency(a));
    @(posedge clk);
    @(negedge clk);
    input_a_stb = 1'b0;
    chk("ack_low_after_accept", {31'd0, input_a_ack}, 32'd0);
  endtask

  // Count edges until output_z_stb rises, then compare value and latency.
  task automatic recv(input string tag);
    int          n = 0;
    logic [31:0] exp_z;
    int          exp_l;
    while (!output_z_stb && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_stb"}, {31'd0, output_z_stb}, 32'd1);
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      exp_z = sb_q.pop_front();
      exp_l = lat_q.pop_front();
      chk({tag, "_latency"}, n, exp_l);
      chk(tag, output_z, exp_z);
    end
  endtask

  task automatic take_result();
    output_z_ack = 1'b1;
    @(negedge clk);
    output_z_ack = 1'b0;
    chk("stb_drop", {31'd0, output_z_stb}, 32'd0);
  endtask

  logic [31:0] vec [0:10];
  logic [31:0] held;

  initial begin
    vec[0]  = 32'h0000_0001;
    vec[1]  = 32'hFFFF_FFFF;
    vec[2]  = 32'h8000_0000;
    vec[3]  = 32'h0100_0001;
    vec[4]  = 32'h0100_0003;
    vec[5]  = 32'h7FFF_FFFF;
    vec[6]  = 32'h0000_0000;
    vec[7]  = $urandom;
    vec[8]  = $urandom;
    vec[9]  = $urandom | 32'h8000_0000;
    vec[10] = $urandom_range(255, 1);

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("rst_stb", {31'd0, output_z_stb}, 32'd0);
    chk("rst_z", output_z, 32'd0);
    rst = 1'b1;

    // Directed and random conversions
    for (int i = 0; i < 11; i++) begin
      send(vec[i]);
      recv($sformatf("conv_%08h", vec[i]));
      take_result();
    end

    // Fixed expectations from the test plan
    chk("ref_one", ref_float(32'h0000_0001), 32'h3F80_0000);
    chk("ref_carry", ref_float(32'h7FFF_FFFF), 32'h4F00_0000);

    // Backpressure: result must hold while ack stays low
    send(32'h1234_5678);
    recv("bp_conv");
    held = output_z;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stb_hold", {31'd0, output_z_stb}, 32'd1);
      chk("bp_z_hold", output_z, held);
      chk("bp_in_ack_low", {31'd0, input_a_ack}, 32'd0);
    end
    take_result();
    chk("bp_in_ack_still_low", {31'd0, input_a_ack}, 32'd0);
    @(negedge clk);
    chk("bp_in_ack_back", {31'd0, input_a_ack}, 32'd1);

    // Reset in the middle of a conversion
    send(32'h0000_0001);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_ack", {31'd0, input_a_ack}, 32'd0);
    chk("midrst_stb", {31'd0, output_z_stb}, 32'd0);
    sb_q.delete();
    lat_q.delete();
    send(32'h0000_0064);
    recv("post_rst_100");
    chk("post_rst_100_value", output_z, 32'h42C8_0000);
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/int_to_float.md
Name: int_to_float

Overview:
- Converts a 32-bit two's-complement signed integer to an IEEE-754 single-precision float.
- Rounding is round-to-nearest-even.
- Sits directly upstream of the single-precision adder, so integer operands (counters, ADC samples) can enter the float datapath.
- Uses the same stb/ack streaming handshake as the adder on both sides.

Parameters:
- None. Fixed 32-bit integer in, binary32 out.

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-low
- input_a  input  32  signed integer operand
- input_a_stb  input  1  upstream: input_a valid
- input_a_ack  output  1  block ready; transfer when stb and ack are both high at a clk edge
- output_z  output  32  binary32 result
- output_z_stb  output  1  output_z valid
- output_z_ack  input  1  downstream accepts; transfer when stb and ack are both high

Behaviour:
- Reset (rst==0 at a clk edge): state<=get_a, input_a_ack<=0, output_z_stb<=0, output_z<=0.
  - Reset overrides any state action in the same cycle, including mid-normalise and mid put_z.
- get_a: input_a_ack<=1 (registered, so first high one cycle after entry).
  - On ack&&stb: latch a<=input_a, ack<=0, go to convert_0.
- convert_0:
  - If a==0: z<=0x00000000 (never -0), go to put_z.
  - Else: z_s<=a[31]; mag<=a[31] ? -a : a, as 32-bit unsigned (0x80000000 stays 0x80000000); z_e<=31 (unbiased, 8-bit signed); go to convert_1.
- convert_1 (normalise):
  - While mag[31]==0: mag<=mag<<1, z_e<=z_e-1, one bit per cycle.
  - Once mag[31]==1: z_m[23:0]<=mag[31:8], guard<=mag[7], round_bit<=mag[6], sticky<=|mag[5:0]; go to round.
- round: if guard && (round_bit|sticky|z_m[0]): z_m<=z_m+1.
  - If z_m==24'hFFFFFF, also z_e<=z_e+1; z_m wraps to 0, and the hidden bit is implicit.
  - Go to pack.
- pack: z[31]<=z_s, z[30:23]<=z_e+127, z[22:0]<=z_m[22:0]; go to put_z.
  - No overflow, denormal or NaN case exists, since |a| <= 2^31.
- put_z: output_z_stb<=1, output_z<=z.
  - On stb&&ack: stb<=0, go to get_a.
  - output_z stays stable while stb is high and ack is low.
- Latency, counted from the accepting edge to the edge that raises output_z_stb:
  - nonzero input: 5 + lz cycles, where lz = leading zeros of mag (0..31)
  - zero input: 2 cycles
- input_a_ack is low from acceptance until the block returns to get_a; one operand in flight.

Optional Feature:
- Macro: INT_TO_FLOAT_FAST_NORMALISE_EN
- Defined: convert_1 takes exactly one cycle.
  - A combinational priority encoder computes lz.
  - mag<<lz and z_e<=31-lz are applied before z_m/guard/round_bit/sticky are extracted.
  - Nonzero latency is a fixed 5 cycles; zero input stays at 2.
- Undefined: iterative one-bit shift as above; results are bit-identical in both builds.

Test Plan:
- input_a=0x00000001 -> output_z=0x3F800000; stb raised 36 cycles after accept (5 with the macro defined).
- input_a=0xFFFFFFFF (-1) -> 0xBF800000; input_a=0x80000000 -> 0xCF000000.
- Rounding:
  - 0x01000001 -> 0x4B800000 (tie, to even)
  - 0x01000003 -> 0x4B800002 (tie, round up)
  - 0x7FFFFFFF -> 0x4F000000 (mantissa carry into exponent)
- input_a=0x00000000 -> 0x00000000 with stb 2 cycles after accept; never 0x80000000.
- Backpressure:
  - Hold output_z_ack low 10 cycles -> output_z and stb stay constant, input_a_ack stays 0.
  - Then raise ack -> stb drops on the next edge; input_a_ack returns high one cycle after re-entering get_a.
- Reset:
  - Drive rst=0 for one edge during convert_1 -> input_a_ack and output_z_stb are 0 after that edge.
  - A following conversion of 0x00000064 (100) -> 0x42C80000.
